vga_sync: RTL and testbench

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock. Outputs the current pixel coordinates, the sync pulses, the visible-area flag and a once-per-frame `refresh_tick`. It sits upstream of `square_controller`, which uses `refresh_tick` to move the square once per frame. `x`/`y` also feed the pixel/colour generator.

---
 rtl/vga_sync.sv | 124 ++++++++++++
 tb/tb_vga_sync.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// vga_sync: 640x480 @ 60 Hz VGA timing generator driven from a 100 MHz clock.
// A clock divider produces a one-clk pixel enable (p_tick) every CLK_DIV
// cycles. The x/y pixel counters advance on that enable. The sync and
// visible-area flags are registered from the counters' next state, so they
// stay in the same cycle as x/y. refresh_tick marks one clk per frame,
// during blanking, for the downstream position updater.
// Optional feature: define VGA_FRAME_COUNT_EN to add the 16-bit frame_count
// output. It counts refresh_tick pulses since reset and wraps at 65535.
module vga_sync #(
  parameter int H_DISPLAY    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_DISPLAY    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int CLK_DIV      = 4,
  parameter int REFRESH_LINE = 481
) (
  input  logic        clk,
  input  logic        reset,
  output logic        p_tick,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
`ifdef VGA_FRAME_COUNT_EN
  output logic [15:0] frame_count,
`endif
  output logic        refresh_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] REF_LINE = 10'(REFRESH_LINE);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // Next-state for divider, pixel counters and the flags derived from them
  always_comb begin
    div_d = div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      div_d = '0;
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Flags come from the next counter values so they land with x/y.
    hsync_d    = ~((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d    = ~((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
  end

  // Timing state registers with synchronous reset to pixel (0,0)
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
    end else begin
      div_q      <= div_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign p_tick       = tick;
  assign x            = x_q;
  assign y            = y_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_on     = video_on_q;
  // Last clk of pixel (0, REFRESH_LINE): once per frame, inside blanking.
  assign refresh_tick = tick && (x_q == 10'd0) && (y_q == REF_LINE);

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  // Frame counter advancing on each refresh pulse, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (refresh_tick) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Testbench for vga_sync. One reduced-geometry instance gets cycle-accurate
// scoreboard checks over several frames. A default-geometry instance is used
// for checking the 640x480 line-0 horizontal boundaries.
module tb_vga_sync;

  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 2;
  localparam int DIV = 4, RL = 7;
  localparam int HT = HD + HF + HS + HB;   // 15
  localparam int VT = VD + VF + VS + VB;   // 11

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       s_pt, s_hs, s_vs, s_von, s_rt;
  logic [9:0] s_x, s_y;
  logic       d_pt, d_hs, d_vs, d_von, d_rt;
  logic [9:0] d_x, d_y;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] s_fc, d_fc;
`endif

  vga_sync #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(DIV), .REFRESH_LINE(RL)
  ) dut_small (
    .clk(clk), .reset(rst), .p_tick(s_pt), .x(s_x), .y(s_y),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
`ifdef VGA_FRAME_COUNT_EN
    .frame_count(s_fc),
`endif
    .refresh_tick(s_rt)
  );

  vga_sync dut_dflt (
    .clk(clk), .reset(rst), .p_tick(d_pt), .x(d_x), .y(d_y),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
`ifdef VGA_FRAME_COUNT_EN
    .frame_count(d_fc),
`endif
    .refresh_tick(d_rt)
  );

  typedef struct packed {
    logic        pt;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        rt;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];

  int n_asserts = 0;
  int n_fails   = 0;

  // reference model state (small instance)
  int m_div = 0, m_x = 0, m_y = 0, m_fc = 0;

  // small-instance statistics
  int hs_low = 0, vs_low = 0, rt_cnt = 0, rt_bad = 0, wraps = 0;
  logic [9:0] s_prev_x = '0, s_prev_y = '0;

  // default-instance line-0 statistics
  bit   d_track = 1'b0;
  int   d_hs_clks = 0, d_hs_first = -1, d_hs_last = -1, d_vo_fall = -1;
  int   d_wrap_y = -1, d_max_x = 0;
  logic [9:0] d_prev_x = '0;
  logic       d_prev_von = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.pt = s_pt; o.x = s_x; o.y = s_y; o.hs = s_hs; o.vs = s_vs;
    o.von = s_von; o.rt = s_rt;
`ifdef VGA_FRAME_COUNT_EN
    o.fc = s_fc;
`else
    o.fc = 16'd0;
`endif
    return o;
  endfunction

  // Drive one clock of stimulus, push the model's prediction, then compare.
  task automatic step(input logic r);
    exp_t e, got;
    @(negedge clk);
    rst = r;
    if (r) begin
      m_div = 0; m_x = 0; m_y = 0; m_fc = 0;
    end else begin
      if (m_div == DIV - 1 && m_x == 0 && m_y == RL) m_fc = (m_fc + 1) % 65536;
      if (m_div == DIV - 1) begin
        m_div = 0;
        if (m_x == HT - 1) begin
          m_x = 0;
          m_y = (m_y == VT - 1) ? 0 : m_y + 1;
        end else begin
          m_x = m_x + 1;
        end
      end else begin
        m_div = m_div + 1;
      end
    end
    e.pt  = (m_div == DIV - 1);
    e.x   = 10'(m_x);
    e.y   = 10'(m_y);
    e.hs  = !(m_x >= HD + HF && m_x < HD + HF + HS);
    e.vs  = !(m_y >= VD + VF && m_y < VD + VF + VS);
    e.von = (m_x < HD) && (m_y < VD);
    e.rt  = e.pt && (m_x == 0) && (m_y == RL);
`ifdef VGA_FRAME_COUNT_EN
    e.fc  = 16'(m_fc);
`else
    e.fc  = 16'd0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = observe();
    e = sb.pop_front();
    chk("cycle", 64'(got), 64'(e));

    if (!s_hs) hs_low++;
    if (!s_vs) vs_low++;
    if (s_rt) begin
      rt_cnt++;
      if (!(s_x == 10'd0 && s_y == 10'(RL) && s_pt && !s_von)) rt_bad++;
    end
    if (s_prev_x == 10'(HT - 1) && s_prev_y == 10'(VT - 1) && s_x == 10'd0 && s_y == 10'd0)
      wraps++;
    s_prev_x = s_x;
    s_prev_y = s_y;

    if (d_track) begin
      if (d_y == 10'd0 && !d_hs) begin
        d_hs_clks++;
        if (d_hs_first < 0) d_hs_first = int'(d_x);
        d_hs_last = int'(d_x);
      end
      if (d_prev_von && !d_von && d_vo_fall < 0) d_vo_fall = int'(d_x);
      if (int'(d_x) > d_max_x) d_max_x = int'(d_x);
      if (d_prev_x == 10'd799 && d_x == 10'd0 && d_wrap_y < 0) d_wrap_y = int'(d_y);
    end
    d_prev_x   = d_x;
    d_prev_von = d_von;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_x"},   64'(s_x),   64'd0);
    chk({tag, "_y"},   64'(s_y),   64'd0);
    chk({tag, "_hs"},  64'(s_hs),  64'd1);
    chk({tag, "_vs"},  64'(s_vs),  64'd1);
    chk({tag, "_von"}, 64'(s_von), 64'd1);
    chk({tag, "_pt"},  64'(s_pt),  64'd0);
    chk({tag, "_rt"},  64'(s_rt),  64'd0);
`ifdef VGA_FRAME_COUNT_EN
    chk({tag, "_fc"},  64'(s_fc),  64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit hit;

    // Reset for a few clocks
    repeat (3) step(1'b1);
    check_reset_values("reset");
    chk("dflt_reset_x",  64'(d_x),  64'd0);
    chk("dflt_reset_hs", 64'(d_hs), 64'd1);

    // Release: first p_tick three clocks later, x 0 -> 1 on it
    d_track = 1'b1;
    cnt = 0;
    do begin
      step(1'b0);
      cnt++;
    end while (!s_pt && cnt < 10);
    chk("first_ptick_latency", 64'(cnt), 64'd3);
    chk("x_at_first_ptick", 64'(s_x), 64'd0);
    step(1'b0);
    chk("x_after_first_ptick", 64'(s_x), 64'd1);
    chk("ptick_low_after", 64'(s_pt), 64'd0);

    // Three full frames of the reduced geometry
    hs_low = 0; vs_low = 0; rt_cnt = 0; rt_bad = 0; wraps = 0;
    repeat (3 * HT * VT * DIV) step(1'b0);
    chk("hsync_low_clks", 64'(hs_low), 64'(3 * VT * HS * DIV));
    chk("vsync_low_clks", 64'(vs_low), 64'(3 * VS * HT * DIV));
    chk("refresh_pulses", 64'(rt_cnt), 64'd3);
    chk("refresh_position", 64'(rt_bad), 64'd0);
    chk("frame_wraps", 64'(wraps), 64'd3);
`ifdef VGA_FRAME_COUNT_EN
    chk("frame_count_3", 64'(s_fc), 64'd3);
`endif

    // Finish line 0 of the default-geometry instance
    repeat (1400) step(1'b0);
    chk("dflt_hs_clks",  64'(d_hs_clks),  64'd384);
    chk("dflt_hs_first", 64'(d_hs_first), 64'd656);
    chk("dflt_hs_last",  64'(d_hs_last),  64'd751);
    chk("dflt_vo_fall",  64'(d_vo_fall),  64'd640);
    chk("dflt_max_x",    64'(d_max_x),    64'd799);
    chk("dflt_wrap_y",   64'(d_wrap_y),   64'd1);

    // Mid-frame reset at x=10, y=5
    hit = 1'b0;
    cnt = 0;
    while (!hit && cnt < 2 * HT * VT * DIV) begin
      step(1'b0);
      cnt++;
      if (s_x == 10'd10 && s_y == 10'd5) hit = 1'b1;
    end
    chk("midframe_reached", 64'(hit), 64'd1);
    rt_cnt = 0;
    step(1'b1);
    check_reset_values("midreset");
    chk("dflt_midreset_y", 64'(d_y), 64'd0);
    cnt = 0;
    do begin
      step(1'b0);
      cnt++;
    end while (!s_pt && cnt < 10);
    chk("ptick_latency_after_midreset", 64'(cnt), 64'd3);
    step(1'b0);
    chk("x_after_midreset_tick", 64'(s_x), 64'd1);
    chk("no_spurious_refresh", 64'(rt_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
